// File: rtl/nn_fabric_pkg.sv
// Shared types and constants for the multicore NN Wishbone fabric.
// Optional broadcast writes are enabled by defining NN_FABRIC_BROADCAST_EN.
package nn_fabric_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FWD  = 2'd1,
        ST_RESP = 2'd2
    } fab_state_t;

    localparam int unsigned OFF_IRQ_MASK = 0;
    localparam int unsigned OFF_IRQ_PEND = 1;
    localparam int unsigned OFF_STATUS   = 2;
    localparam int unsigned OFF_ID       = 3;

    localparam logic [15:0] ID_MAGIC  = 16'h4E4E;
    localparam logic [7:0]  ID_REV    = 8'h02;
    localparam logic [31:0] DEAD_BEEF = 32'hDEAD_BEEF;

    // Expand Wishbone byte selects into a 32-bit bit mask.
    function automatic logic [31:0] sel_to_mask(input logic [3:0] sel);
        logic [31:0] m;
        for (int b = 0; b < 4; b++) begin
            m[8*b +: 8] = {8{sel[b]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/nn_irq_aggregator.sv
// Core interrupt aggregation: rising-edge capture into a W1C pending register,
// a RW mask, and a registered OR of the unmasked pending bits.
module nn_irq_aggregator #(
    parameter int unsigned N_CORES = 4
)(
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [N_CORES-1:0] i_core_irq,
    input  logic               i_wr_mask,
    input  logic               i_wr_pend,
    input  logic [N_CORES-1:0] i_wdata,
    input  logic [N_CORES-1:0] i_bmask,
    output logic [N_CORES-1:0] o_mask,
    output logic [N_CORES-1:0] o_pend,
    output logic               o_irq
);

    logic [N_CORES-1:0] r_irq_prev;
    logic [N_CORES-1:0] r_mask;
    logic [N_CORES-1:0] r_pend;
    logic               r_irq;
    logic [N_CORES-1:0] w_rise;
    logic [N_CORES-1:0] w_clr;

    assign w_rise = i_core_irq & ~r_irq_prev;
    assign w_clr  = i_wr_pend ? (i_wdata & i_bmask) : '0;

    // A new edge in the same cycle as a W1C clear keeps the bit set.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_irq_prev <= '0;
            r_mask     <= '0;
            r_pend     <= '0;
            r_irq      <= 1'b0;
        end else begin
            r_irq_prev <= i_core_irq;
            r_pend     <= (r_pend & ~w_clr) | w_rise;
            if (i_wr_mask) begin
                r_mask <= (r_mask & ~i_bmask) | (i_wdata & i_bmask);
            end
            r_irq <= |(r_pend & r_mask);
        end
    end

    assign o_mask = r_mask;
    assign o_pend = r_pend;
    assign o_irq  = r_irq;

endmodule

// File: rtl/nn_multicore_wb_fabric.sv
// Wishbone slave fabric routing single transfers to N_CORES NN cores plus a control window.
// Define NN_FABRIC_BROADCAST_EN to turn upper control-window writes into all-core broadcasts.
module nn_multicore_wb_fabric
    import nn_fabric_pkg::*;
#(
    parameter int unsigned N_CORES   = 4,
    parameter int unsigned ADDR_W    = 8,
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int unsigned TIMEOUT   = 255
)(
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_ni,
    input  logic                   wbs_cyc_i,
    input  logic                   wbs_stb_i,
    input  logic                   wbs_we_i,
    input  logic [3:0]             wbs_sel_i,
    input  logic [31:0]            wbs_adr_i,
    input  logic [31:0]            wbs_dat_i,
    output logic                   wbs_ack_o,
    output logic [31:0]            wbs_dat_o,
    output logic [N_CORES-1:0]     core_req_o,
    output logic                   core_we_o,
    output logic [3:0]             core_sel_o,
    output logic [ADDR_W-1:0]      core_adr_o,
    output logic [31:0]            core_dat_o,
    input  logic [N_CORES-1:0]     core_ack_i,
    input  logic [32*N_CORES-1:0]  core_dat_i,
    input  logic [N_CORES-1:0]     core_irq_i,
    output logic [2:0]             irq_o,
    output logic [1:0]             dbg_state_o
);

    localparam int unsigned IDX_W = $clog2(N_CORES + 1);
    localparam int unsigned UP_LO = ADDR_W + 2 + IDX_W;

    // Core handshake: core_req_o[k] is held high with stable we/sel/adr/dat until
    // the fabric samples core_ack_i[k] high, the transfer times out, or cyc drops.
    fab_state_t          r_state;
    fab_state_t          w_state_nxt;

    logic [N_CORES-1:0]  r_req;
    logic                r_we;
    logic [3:0]          r_sel;
    logic [ADDR_W-1:0]   r_adr;
    logic [31:0]         r_wdat;
    logic [IDX_W-1:0]    r_idx;
    logic                r_bcast;
    logic [7:0]          r_cnt;
    logic                r_ack;
    logic [31:0]         r_rdat;
    logic                r_st_to;
    logic [3:0]          r_st_core;

    logic [IDX_W-1:0]    w_idx;
    logic [ADDR_W-1:0]   w_off;
    logic                w_hit;
    logic                w_core_hit;
    logic                w_ctrl_hit;
    logic                w_bcast;
    logic [ADDR_W-1:0]   w_fwd_adr;
    logic [N_CORES-1:0]  w_onehot;
    logic [31:0]         w_core_rdat;
    logic [31:0]         w_ctrl_rdat;
    logic [31:0]         w_bmask;
    logic [7:0]          w_cnt_nxt;
    logic                w_accept_fwd;
    logic                w_accept_resp;
    logic                w_fwd_done;
    logic                w_fwd_to;
    logic                w_abort;
    logic                w_wr_ctrl;
    logic [N_CORES-1:0]  w_mask;
    logic [N_CORES-1:0]  w_pend;
    logic                w_irq_core;
    logic                w_unused;

    assign w_idx      = wbs_adr_i[ADDR_W+2 +: IDX_W];
    assign w_off      = wbs_adr_i[ADDR_W+1:2];
    assign w_hit      = (wbs_adr_i[31:UP_LO] == BASE_ADDR[31:UP_LO]);
    assign w_core_hit = w_hit && (32'(w_idx) < N_CORES);
    assign w_ctrl_hit = w_hit && (32'(w_idx) == N_CORES);
    assign w_bmask    = sel_to_mask(wbs_sel_i);
    assign w_cnt_nxt  = r_cnt + 8'd1;
    assign w_unused   = ^{wbs_adr_i[1:0], w_bmask};

`ifdef NN_FABRIC_BROADCAST_EN
    assign w_bcast = w_ctrl_hit && wbs_we_i && w_off[ADDR_W-1];
`else
    assign w_bcast = 1'b0;
`endif

    assign w_fwd_adr = w_bcast ? {1'b0, w_off[ADDR_W-2:0]} : w_off;

    always_comb begin
        w_onehot    = '0;
        w_core_rdat = '0;
        for (int k = 0; k < N_CORES; k++) begin
            if (32'(w_idx) == k) w_onehot[k] = 1'b1;
            if (32'(r_idx) == k) w_core_rdat = core_dat_i[32*k +: 32];
        end
    end

    always_comb begin
        w_ctrl_rdat = '0;
        if (w_off == ADDR_W'(OFF_IRQ_MASK))      w_ctrl_rdat = 32'(w_mask);
        else if (w_off == ADDR_W'(OFF_IRQ_PEND)) w_ctrl_rdat = 32'(w_pend);
        else if (w_off == ADDR_W'(OFF_STATUS))   w_ctrl_rdat = {20'd0, r_st_core, 7'd0, r_st_to};
        else if (w_off == ADDR_W'(OFF_ID))       w_ctrl_rdat = {ID_MAGIC, 8'(N_CORES), ID_REV};
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) r_state <= ST_IDLE;
        else            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_accept_fwd  = 1'b0;
        w_accept_resp = 1'b0;
        w_fwd_done    = 1'b0;
        w_fwd_to      = 1'b0;
        w_abort       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (wbs_cyc_i && wbs_stb_i) begin
                    if (w_core_hit || w_bcast) begin
                        w_accept_fwd = 1'b1;
                        w_state_nxt  = ST_FWD;
                    end else begin
                        w_accept_resp = 1'b1;
                        w_state_nxt   = ST_RESP;
                    end
                end
            end
            ST_FWD: begin
                if (!wbs_cyc_i) begin
                    w_abort     = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if ((r_req & ~core_ack_i) == '0) begin
                    w_fwd_done  = 1'b1;
                    w_state_nxt = ST_RESP;
                end else if (w_cnt_nxt == 8'(TIMEOUT)) begin
                    // FWD lasts at most TIMEOUT cycles before the forced response.
                    w_fwd_to    = 1'b1;
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_wr_ctrl = w_accept_resp && w_ctrl_hit && wbs_we_i;

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_req     <= '0;
            r_we      <= 1'b0;
            r_sel     <= '0;
            r_adr     <= '0;
            r_wdat    <= '0;
            r_idx     <= '0;
            r_bcast   <= 1'b0;
            r_cnt     <= '0;
            r_ack     <= 1'b0;
            r_rdat    <= '0;
            r_st_to   <= 1'b0;
            r_st_core <= '0;
        end else begin
            r_ack <= w_accept_resp | w_fwd_done | w_fwd_to;

            if (w_accept_fwd) begin
                r_req   <= w_bcast ? '1 : w_onehot;
                r_we    <= wbs_we_i;
                r_sel   <= wbs_sel_i;
                r_adr   <= w_fwd_adr;
                r_wdat  <= wbs_dat_i;
                r_idx   <= w_idx;
                r_bcast <= w_bcast;
                r_cnt   <= '0;
            end else if (w_fwd_done || w_fwd_to || w_abort) begin
                r_req <= '0;
            end else if (r_state == ST_FWD) begin
                // Broadcast: each core's request drops as soon as that core acks.
                r_req <= r_req & ~core_ack_i;
                r_cnt <= w_cnt_nxt;
            end

            if (w_accept_resp)    r_rdat <= (w_ctrl_hit && !wbs_we_i) ? w_ctrl_rdat : '0;
            else if (w_fwd_done)  r_rdat <= r_bcast ? '0 : w_core_rdat;
            else if (w_fwd_to)    r_rdat <= DEAD_BEEF;
            else if (r_state == ST_RESP) r_rdat <= '0;

            if (w_fwd_to) begin
                r_st_to   <= 1'b1;
                r_st_core <= r_bcast ? 4'hF : 4'(r_idx);
            end else if (w_wr_ctrl && (w_off == ADDR_W'(OFF_STATUS)) && w_bmask[0] && wbs_dat_i[0]) begin
                r_st_to <= 1'b0;
            end
        end
    end

    nn_irq_aggregator #(
        .N_CORES (N_CORES)
    ) u_irq (
        .i_clk      (wb_clk_i),
        .i_rst_n    (wb_rst_ni),
        .i_core_irq (core_irq_i),
        .i_wr_mask  (w_wr_ctrl && (w_off == ADDR_W'(OFF_IRQ_MASK))),
        .i_wr_pend  (w_wr_ctrl && (w_off == ADDR_W'(OFF_IRQ_PEND))),
        .i_wdata    (wbs_dat_i[N_CORES-1:0]),
        .i_bmask    (w_bmask[N_CORES-1:0]),
        .o_mask     (w_mask),
        .o_pend     (w_pend),
        .o_irq      (w_irq_core)
    );

    assign wbs_ack_o   = r_ack;
    assign wbs_dat_o   = r_rdat;
    assign core_req_o  = r_req;
    assign core_we_o   = r_we;
    assign core_sel_o  = r_sel;
    assign core_adr_o  = r_adr;
    assign core_dat_o  = r_wdat;
    assign irq_o       = {1'b0, r_st_to, w_irq_core};
    assign dbg_state_o = r_state;

endmodule

// File: tb/tb_nn_multicore_wb_fabric.sv
// Self-checking bench for nn_multicore_wb_fabric: Wishbone driver, per-core responders
// with programmable ack delay, and an expected-data/latency scoreboard.
module tb_nn_multicore_wb_fabric;

    localparam int          N    = 4;
    localparam int          TO   = 255;
    localparam logic [31:0] BASE = 32'h3000_0000;
    localparam logic [31:0] CTRL = 32'h3000_1000;

    logic            clk;
    logic            rst_n;
    logic            cyc, stb, we_i;
    logic [3:0]      sel_i;
    logic [31:0]     adr_i, dat_i;
    logic            wbs_ack_o;
    logic [31:0]     wbs_dat_o;
    logic [N-1:0]    core_req_o;
    logic            core_we_o;
    logic [3:0]      core_sel_o;
    logic [7:0]      core_adr_o;
    logic [31:0]     core_dat_o;
    logic [N-1:0]    core_ack_i;
    logic [32*N-1:0] core_dat_i;
    logic [N-1:0]    core_irq_i;
    logic [2:0]      irq_o;
    logic [1:0]      dbg_state_o;

    logic [31:0] exp_q[$];
    int          lat_q[$];
    int          n_checks = 0;
    int          n_errors = 0;

    int          core_delay[N];
    int          core_cnt[N];
    logic [31:0] core_data[N];

    nn_multicore_wb_fabric #(
        .N_CORES(N), .ADDR_W(8), .BASE_ADDR(BASE), .TIMEOUT(TO)
    ) dut (
        .wb_clk_i   (clk),
        .wb_rst_ni  (rst_n),
        .wbs_cyc_i  (cyc),
        .wbs_stb_i  (stb),
        .wbs_we_i   (we_i),
        .wbs_sel_i  (sel_i),
        .wbs_adr_i  (adr_i),
        .wbs_dat_i  (dat_i),
        .wbs_ack_o  (wbs_ack_o),
        .wbs_dat_o  (wbs_dat_o),
        .core_req_o (core_req_o),
        .core_we_o  (core_we_o),
        .core_sel_o (core_sel_o),
        .core_adr_o (core_adr_o),
        .core_dat_o (core_dat_o),
        .core_ack_i (core_ack_i),
        .core_dat_i (core_dat_i),
        .core_irq_i (core_irq_i),
        .irq_o      (irq_o),
        .dbg_state_o(dbg_state_o)
    );

    // Clock and watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    always_comb begin
        core_dat_i = '0;
        for (int k = 0; k < N; k++) core_dat_i[32*k +: 32] = core_data[k];
    end

    // Core responders: with delay d, core k acks d cycles after its request rises.
    initial begin
        core_ack_i = '0;
        for (int k = 0; k < N; k++) core_cnt[k] = 0;
        forever begin
            @(negedge clk);
            for (int k = 0; k < N; k++) begin
                if (core_ack_i[k]) begin
                    core_ack_i[k] = 1'b0;
                    core_cnt[k]   = 0;
                end else if (core_req_o[k] && rst_n) begin
                    core_cnt[k]++;
                    if (core_delay[k] != 0 && core_cnt[k] == core_delay[k]) core_ack_i[k] = 1'b1;
                end else begin
                    core_cnt[k] = 0;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One Wishbone transfer; latency = clock edges from the edge sampling stb
    // up to and including the edge at which the master samples ack.
    task automatic wb_xfer(input string tag, input logic we, input logic [31:0] adr,
                           input logic [31:0] dat, input logic [3:0] sel,
                           input logic [31:0] exp_dat, input int exp_lat,
                           output logic [N-1:0] req_seen);
        int   k;
        logic got;
        exp_q.push_back(exp_dat);
        lat_q.push_back(exp_lat);
        req_seen = '0;
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we_i = we; adr_i = adr; dat_i = dat; sel_i = sel;
        k = 0;
        got = 1'b0;
        while (!got && k < 400) begin
            @(negedge clk);
            k++;
            req_seen |= core_req_o;
            if (wbs_ack_o) got = 1'b1;
        end
        cyc = 1'b0; stb = 1'b0; we_i = 1'b0;
        chk({tag, "_ack_seen"}, 32'(got), 32'd1);
        if (got) begin
            chk({tag, "_dat"}, wbs_dat_o, exp_q.pop_front());
            chk({tag, "_lat"}, 32'(k + 1), 32'(lat_q.pop_front()));
            @(negedge clk);
            chk({tag, "_ack_pulse"}, 32'(wbs_ack_o), 32'd0);
        end else begin
            void'(exp_q.pop_front());
            void'(lat_q.pop_front());
        end
    endtask

    task automatic pulse_irq(input int k);
        @(negedge clk);
        core_irq_i[k] = 1'b1;
        @(negedge clk);
        core_irq_i[k] = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        logic [N-1:0] req;
        logic         ack_any;
        int           c, d, off;
        logic [31:0]  v, wd;

        cyc = 0; stb = 0; we_i = 0; sel_i = 0; adr_i = 0; dat_i = 0;
        core_irq_i = '0;
        for (int k = 0; k < N; k++) begin
            core_delay[k] = 1;
            core_data[k]  = 32'hC0DE_0000 + 32'(k);
        end
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ack", 32'(wbs_ack_o), 0);
        chk("rst_dat", wbs_dat_o, 0);
        chk("rst_req", 32'(core_req_o), 0);
        chk("rst_irq", 32'(irq_o), 0);
        chk("rst_state", 32'(dbg_state_o), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Core 2 read, ack after 3 cycles
        core_delay[2] = 3;
        core_data[2]  = 32'h1234_5678;
        wb_xfer("c2_rd", 0, BASE | (32'd2 << 10) | (32'd5 << 2), 0, 4'hF, 32'h1234_5678, 5, req);
        chk("c2_req", 32'(req), 32'b0100);
        chk("c2_adr", 32'(core_adr_o), 5);
        chk("c2_we", 32'(core_we_o), 0);

        // Random core transfers
        for (int i = 0; i < 8; i++) begin
            c   = $urandom_range(0, N - 1);
            d   = $urandom_range(1, 6);
            off = $urandom_range(0, 255);
            v   = $urandom;
            wd  = $urandom;
            core_delay[c] = d;
            core_data[c]  = v;
            wb_xfer("rnd", i[0], BASE | (32'(c) << 10) | (32'(off) << 2), wd, 4'hF, v, d + 2, req);
            chk("rnd_req", 32'(req), 32'(1) << c);
            chk("rnd_adr", 32'(core_adr_o), 32'(off));
            chk("rnd_we", 32'(core_we_o), 32'(i[0]));
            if (i[0]) chk("rnd_wdat", core_dat_o, wd);
        end
        for (int k = 0; k < N; k++) core_delay[k] = 1;

        // Timeout on a core write, then STATUS readback and W1C
        core_delay[0] = 0;
        wb_xfer("to_wr", 1, BASE | (32'd7 << 2), 32'hAAAA_5555, 4'hF, 32'hDEAD_BEEF, TO + 2, req);
        chk("to_irq1_set", 32'(irq_o[1]), 1);
        wb_xfer("st_rd0", 0, CTRL | 32'h8, 0, 4'hF, 32'h0000_0001, 2, req);
        wb_xfer("st_w1c", 1, CTRL | 32'h8, 32'h1, 4'hF, 0, 2, req);
        chk("to_irq1_clr", 32'(irq_o[1]), 0);
        core_delay[0] = 1;
        core_delay[3] = 0;
        wb_xfer("to_rd", 0, BASE | (32'd3 << 10), 0, 4'hF, 32'hDEAD_BEEF, TO + 2, req);
        wb_xfer("st_rd3", 0, CTRL | 32'h8, 0, 4'hF, 32'h0000_0301, 2, req);
        wb_xfer("st_w1c3", 1, CTRL | 32'h8, 32'h1, 4'hF, 0, 2, req);
        core_delay[3] = 1;

        // Interrupt aggregation
        wb_xfer("mask_wr", 1, CTRL, 32'h2, 4'hF, 0, 2, req);
        pulse_irq(1);
        chk("irq0_set", 32'(irq_o[0]), 1);
        wb_xfer("pend_rd", 0, CTRL | 32'h4, 0, 4'hF, 32'h2, 2, req);
        wb_xfer("pend_w1c", 1, CTRL | 32'h4, 32'h2, 4'hF, 0, 2, req);
        @(negedge clk);
        chk("irq0_clr", 32'(irq_o[0]), 0);
        wb_xfer("pend_rd0", 0, CTRL | 32'h4, 0, 4'hF, 32'h0, 2, req);
        wb_xfer("mask_wr0", 1, CTRL, 32'h0, 4'hF, 0, 2, req);
        pulse_irq(1);
        chk("irq0_masked", 32'(irq_o[0]), 0);
        wb_xfer("pend_rd2", 0, CTRL | 32'h4, 0, 4'hF, 32'h2, 2, req);

        // Byte selects on control writes
        wb_xfer("mask_sel0", 1, CTRL, 32'hF, 4'h0, 0, 2, req);
        wb_xfer("mask_rd_a", 0, CTRL, 0, 4'hF, 32'h0, 2, req);
        wb_xfer("mask_sel1", 1, CTRL, 32'h0000_FF0F, 4'b0010, 0, 2, req);
        wb_xfer("mask_rd_b", 0, CTRL, 0, 4'hF, 32'h0, 2, req);
        wb_xfer("mask_sel0b", 1, CTRL, 32'h5, 4'b0001, 0, 2, req);
        wb_xfer("mask_rd_c", 0, CTRL, 0, 4'hF, 32'h5, 2, req);
        wb_xfer("pend_w1c_s0", 1, CTRL | 32'h4, 32'hF, 4'h0, 0, 2, req);
        wb_xfer("pend_rd_s0", 0, CTRL | 32'h4, 0, 4'hF, 32'h2, 2, req);
        chk("irq0_mask5", 32'(irq_o[0]), 0);

        // Misses, ID and unused offsets
        wb_xfer("miss_rd", 0, 32'h2000_0000, 0, 4'hF, 0, 2, req);
        chk("miss_req", 32'(req), 0);
        wb_xfer("miss_wr", 1, 32'h2000_0000, 32'hFFFF_FFFF, 4'hF, 0, 2, req);
        wb_xfer("idx5_rd", 0, BASE | (32'd5 << 10), 0, 4'hF, 0, 2, req);
        chk("idx5_req", 32'(req), 0);
        wb_xfer("id_rd", 0, CTRL | 32'hC, 0, 4'hF, 32'h4E4E_0402, 2, req);
        wb_xfer("id_wr", 1, CTRL | 32'hC, 32'h0, 4'hF, 0, 2, req);
        wb_xfer("id_rd2", 0, CTRL | 32'hC, 0, 4'hF, 32'h4E4E_0402, 2, req);
        wb_xfer("off4_rd", 0, CTRL | 32'h10, 0, 4'hF, 0, 2, req);
        wb_xfer("hi_rd", 0, CTRL | (32'd133 << 2), 0, 4'hF, 0, 2, req);

        // cyc dropped while forwarding
        core_delay[1] = 0;
        @(negedge clk);
        cyc = 1; stb = 1; we_i = 0; sel_i = 4'hF; adr_i = BASE | (32'd1 << 10);
        repeat (3) @(negedge clk);
        chk("abort_req_on", 32'(core_req_o), 32'b0010);
        chk("abort_state_fwd", 32'(dbg_state_o), 1);
        cyc = 0; stb = 0;
        @(negedge clk);
        chk("abort_req_off", 32'(core_req_o), 0);
        chk("abort_state_idle", 32'(dbg_state_o), 0);
        ack_any = wbs_ack_o;
        repeat (4) begin
            @(negedge clk);
            ack_any |= wbs_ack_o;
        end
        chk("abort_noack", 32'(ack_any), 0);

        // Reset asserted mid-transfer
        wb_xfer("mask_all", 1, CTRL, 32'hF, 4'hF, 0, 2, req);
        @(negedge clk);
        chk("pre_rst_irq0", 32'(irq_o[0]), 1);
        cyc = 1; stb = 1; we_i = 0; adr_i = BASE | (32'd1 << 10);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_req", 32'(core_req_o), 0);
        chk("rst_mid_ack", 32'(wbs_ack_o), 0);
        chk("rst_mid_state", 32'(dbg_state_o), 0);
        chk("rst_mid_irq", 32'(irq_o), 0);
        cyc = 0; stb = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        core_delay[1] = 1;
        wb_xfer("rst_mask_rd", 0, CTRL, 0, 4'hF, 0, 2, req);
        wb_xfer("rst_pend_rd", 0, CTRL | 32'h4, 0, 4'hF, 0, 2, req);

`ifdef NN_FABRIC_BROADCAST_EN
        core_delay[0] = 2; core_delay[1] = 5; core_delay[2] = 3; core_delay[3] = 7;
        wb_xfer("bc_wr", 1, CTRL | (32'd133 << 2), 32'h5A5A_A5A5, 4'hF, 0, 9, req);
        chk("bc_req", 32'(req), 32'hF);
        chk("bc_adr", 32'(core_adr_o), 5);
        chk("bc_wdat", core_dat_o, 32'h5A5A_A5A5);
`endif

        chk("sb_empty", 32'(exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
